// File: rtl/noc_pkg.sv
// Shared definitions for the mesh router injection path.
//   - route direction codes (E/W/N/S/LOCAL)
//   - flit field offsets, expressed as functions of the coordinate width
//   - xy_dir: dimension-ordered (column first, then row) route computation
// Flit layout, MSB to LSB: {valid, dir[2:0], row[COORD_W-1:0], col[COORD_W-1:0]}
package noc_pkg;

  localparam logic [2:0] DIR_E = 3'd0;
  localparam logic [2:0] DIR_W = 3'd1;
  localparam logic [2:0] DIR_N = 3'd2;
  localparam logic [2:0] DIR_S = 3'd3;
  localparam logic [2:0] DIR_L = 3'd4;

  // Coordinates wider than this are not supported by xy_dir.
  localparam int MAX_COORD_W = 16;

  function automatic int valid_bit(input int coord_w);
    return 3 + 2 * coord_w;
  endfunction

  function automatic int dir_msb(input int coord_w);
    return 2 + 2 * coord_w;
  endfunction

  function automatic int dir_lsb(input int coord_w);
    return 2 * coord_w;
  endfunction

  function automatic int row_msb(input int coord_w);
    return 2 * coord_w - 1;
  endfunction

  function automatic int row_lsb(input int coord_w);
    return coord_w;
  endfunction

  function automatic int col_msb(input int coord_w);
    return coord_w - 1;
  endfunction

  function automatic int col_lsb(input int coord_w);
    return 0 * coord_w;
  endfunction

  // Column is resolved first; only when the column matches does the row
  // decide. All comparisons are unsigned (inputs zero-extended by caller).
  function automatic logic [2:0] xy_dir(
    input logic [MAX_COORD_W-1:0] row,
    input logic [MAX_COORD_W-1:0] col,
    input logic [MAX_COORD_W-1:0] my_row,
    input logic [MAX_COORD_W-1:0] my_col
  );
    logic [2:0] d;
    if (col > my_col)      d = DIR_E;
    else if (col < my_col) d = DIR_W;
    else if (row > my_row) d = DIR_N;
    else if (row < my_row) d = DIR_S;
    else                   d = DIR_L;
    return d;
  endfunction

endpackage

// File: rtl/inj_fifo.sv
// Local injection queue: synchronous FIFO with asynchronous active-low reset.
// Ports:
//   clk, rst_n   clock / async active-low reset (flushes pointers and count)
//   push, wdata  write request and data (ignored when full)
//   pop          read request (ignored when empty); rdata shows the head
//   rdata        current head entry (valid only when !empty)
//   count        occupancy, 0..DEPTH
//   empty, full  occupancy flags
module inj_fifo
  import noc_pkg::*;
#(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  // Full check ignores a same-cycle pop: a full queue never takes a push.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset; the flushed pointers make old contents invisible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/flit_injector_pipe.sv
// Bufferless mesh router injection stage. Local destinations are queued with
// their XY route precomputed; each cycle the queue head is placed into the
// first empty inbound channel found by a rotating-priority scan, and all
// channels then pass through one register stage toward the permutation net.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   in_ch        inbound flits, channel i at [i*FLIT_W +: FLIT_W]
//   out_ch       registered outbound flits (one cycle latency)
//   loc_dest     local destination {row, col}
//   loc_valid    local push request
//   loc_ready    queue can accept a push
//   inj_fire     registered: an injection happened in the previous cycle
//   inj_ch       registered: channel used by the last injection
//   fifo_count   queue occupancy
//   starve       head has waited STARVE_MAX cycles without injection
//
// Local handshake: a push is taken on any rising clk edge where loc_valid and
// loc_ready are both high; loc_ready depends only on queue occupancy (never on
// loc_valid or a same-cycle pop) and is low while rst_n is low.
module flit_injector_pipe
  import noc_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int COORD_W    = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int MY_ROW     = 4,
  parameter int MY_COL     = 4,
  parameter int STARVE_MAX = 15
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_CH*(4+2*COORD_W)-1:0]         in_ch,
  output logic [NUM_CH*(4+2*COORD_W)-1:0]         out_ch,
  input  logic [2*COORD_W-1:0]                    loc_dest,
  input  logic                                    loc_valid,
  output logic                                    loc_ready,
  output logic                                    inj_fire,
  output logic [$clog2(NUM_CH)-1:0]               inj_ch,
  output logic [$clog2(FIFO_DEPTH):0]             fifo_count,
  output logic                                    starve
);

  localparam int FLIT_W = 4 + 2 * COORD_W;
  localparam int ENT_W  = 3 + 2 * COORD_W;
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int SW     = $clog2(STARVE_MAX + 1);
  localparam int VB     = valid_bit(COORD_W);

  // ---------------- local queue ----------------
  logic [2:0]             push_dir;
  logic [ENT_W-1:0]       head;
  logic                   q_empty;
  logic                   q_full;
  logic                   inject;

  // Route is fixed at push time and travels with the entry.
  assign push_dir = xy_dir(
    MAX_COORD_W'(loc_dest[row_msb(COORD_W):row_lsb(COORD_W)]),
    MAX_COORD_W'(loc_dest[col_msb(COORD_W):col_lsb(COORD_W)]),
    MAX_COORD_W'(MY_ROW),
    MAX_COORD_W'(MY_COL));

  assign loc_ready = rst_n && !q_full;

  inj_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (loc_valid && loc_ready),
    .pop   (inject),
    .wdata ({push_dir, loc_dest}),
    .rdata (head),
    .count (fifo_count),
    .empty (q_empty),
    .full  (q_full)
  );

  // ---------------- rotating channel selection ----------------
  logic [CH_W-1:0]     rr_ptr;
  logic [NUM_CH-1:0]   ch_free;
  logic [2*NUM_CH-1:0] free_rot;
  logic                found;
  logic [CH_W-1:0]     chosen;
  logic [CH_W:0]       cand;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_free[i] = !in_ch[i*FLIT_W + VB];
    end
  end

  // Rotate the free mask so bit 0 is the channel at rr_ptr; the first set
  // bit at offset k then maps back to channel (rr_ptr + k) mod NUM_CH.
  assign free_rot = {ch_free, ch_free} >> rr_ptr;

  always_comb begin
    found  = 1'b0;
    chosen = '0;
    cand   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && free_rot[k]) begin
        found = 1'b1;
        cand  = {1'b0, rr_ptr} + (CH_W+1)'(k);
        if (cand >= (CH_W+1)'(NUM_CH)) cand = cand - (CH_W+1)'(NUM_CH);
        chosen = cand[CH_W-1:0];
      end
    end
  end

  // The queue head was pushed on an earlier edge, so a same-cycle push
  // into an empty queue cannot be injected until the following cycle.
  assign inject = !q_empty && found;

  // ---------------- outbound register stage ----------------
  logic [NUM_CH*FLIT_W-1:0] out_next;

  // Occupied channels pass through untouched (dir is not recomputed);
  // free channels are normalised to all-zero unless they receive the head.
  always_comb begin
    out_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (inject && (chosen == CH_W'(i))) begin
        out_next[i*FLIT_W +: FLIT_W] = {1'b1, head};
      end else if (!ch_free[i]) begin
        out_next[i*FLIT_W +: FLIT_W] = in_ch[i*FLIT_W +: FLIT_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ch   <= '0;
      inj_fire <= 1'b0;
      inj_ch   <= '0;
      rr_ptr   <= '0;
    end else begin
      out_ch   <= out_next;
      inj_fire <= inject;
      if (inject) begin
        inj_ch <= chosen;
        rr_ptr <= (chosen == CH_W'(NUM_CH - 1)) ? '0 : chosen + 1'b1;
      end
    end
  end

  // ---------------- starvation monitor ----------------
  logic [SW-1:0] starve_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (inject || q_empty) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign starve = (starve_cnt == SW'(STARVE_MAX));

endmodule
